mole_hit_ctrl: RTL

- Game-logic stage directly downstream of the VGA marker tracker.
- Once per frame it samples the tracked marker centre (Avg_X/Avg_Y) and maps it to one of nine holes on a 3x3 grid.
- It runs the whac-a-mole round state machine: pseudo-random mole spawn, up timer, debounced hit detection, score and miss counting.
- Outputs feed the overlay renderer and the score display.

---
 rtl/mole_pkg.sv | 29 ++
 rtl/mole_grid_map.sv | 57 +++++
 rtl/mole_hit_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// Shared encodings and helpers for the whac-a-mole game logic stage.
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_UP   = 3'd2,
    ST_HIT  = 3'd3,
    ST_MISS = 3'd4,
    ST_OVER = 3'd5
  } moleState_t;

  localparam logic [3:0] NO_HOLE   = 4'hF;
  localparam int         H_ACT     = 640;
  localparam int         V_ACT     = 480;
  // Fibonacci taps 8,6,5,4 expressed as a mask on bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [3:0] spawnHole(input logic [7:0] lfsr, input logic [3:0] prevHole);
    logic [3:0] h;
    h = lfsr[3:0];
    if (h >= 4'd9) h = h - 4'd9;
    else           h = h;
    if (h == prevHole) h = (h == 4'd8) ? 4'd0 : h + 4'd1;
    else               h = h;
    return h;
  endfunction

endpackage

// File: rtl/mole_grid_map.sv
// Maps a marker centre onto the 3x3 hole grid; the no-marker code (0,0) and a
// dead zone around every internal cell border both give NO_HOLE.
module mole_grid_map #(
  parameter int CELL_W = 213,
  parameter int CELL_H = 160,
  parameter int MARGIN = 8
) (
  input  logic [10:0] iX,
  input  logic [10:0] iY,
  output logic [3:0]  oHole
);
  import mole_pkg::*;

  localparam logic [11:0] X_LO1 = 12'(CELL_W - MARGIN);
  localparam logic [11:0] X_HI1 = 12'(CELL_W + MARGIN);
  localparam logic [11:0] X_LO2 = 12'(2 * CELL_W - MARGIN);
  localparam logic [11:0] X_HI2 = 12'(2 * CELL_W + MARGIN);
  localparam logic [11:0] Y_LO1 = 12'(CELL_H - MARGIN);
  localparam logic [11:0] Y_HI1 = 12'(CELL_H + MARGIN);
  localparam logic [11:0] Y_LO2 = 12'(2 * CELL_H - MARGIN);
  localparam logic [11:0] Y_HI2 = 12'(2 * CELL_H + MARGIN);

  logic [11:0] xExt_s;
  logic [11:0] yExt_s;
  logic [1:0]  col_s;
  logic [1:0]  row_s;
  logic        inDead_s;

  assign xExt_s = {1'b0, iX};
  assign yExt_s = {1'b0, iY};

  // Column/row selection with clamping, dead-zone test and final hole index.
  always_comb begin
    col_s    = 2'd2;
    row_s    = 2'd2;
    inDead_s = 1'b0;
    oHole    = NO_HOLE;

    if (xExt_s >= 12'(H_ACT))          col_s = 2'd2;
    else if (xExt_s < 12'(CELL_W))     col_s = 2'd0;
    else if (xExt_s < 12'(2 * CELL_W)) col_s = 2'd1;
    else                               col_s = 2'd2;

    if (yExt_s >= 12'(V_ACT))          row_s = 2'd2;
    else if (yExt_s < 12'(CELL_H))     row_s = 2'd0;
    else if (yExt_s < 12'(2 * CELL_H)) row_s = 2'd1;
    else                               row_s = 2'd2;

    inDead_s = (xExt_s > X_LO1 && xExt_s < X_HI1) || (xExt_s > X_LO2 && xExt_s < X_HI2) ||
               (yExt_s > Y_LO1 && yExt_s < Y_HI1) || (yExt_s > Y_LO2 && yExt_s < Y_HI2);

    if (iX == 11'd0 && iY == 11'd0) oHole = NO_HOLE;
    else if (inDead_s)              oHole = NO_HOLE;
    else                            oHole = {2'b00, row_s} * 4'd3 + {2'b00, col_s};
  end

endmodule

// File: rtl/mole_hit_ctrl.sv
// Whac-a-mole round controller: frame-paced mole spawn, up timer, debounced
// hit detection, score and miss bookkeeping.
module mole_hit_ctrl #(
  parameter int         CELL_W     = 213,
  parameter int         CELL_H     = 160,
  parameter int         MARGIN     = 8,
  parameter int         GAP_FRAMES = 20,
  parameter int         UP_FRAMES  = 60,
  parameter int         HIT_FRAMES = 3,
  parameter int         MAX_MISS   = 5,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFrame_Tick,
  input  logic [10:0] iAvg_X,
  input  logic [10:0] iAvg_Y,
  input  logic        iStart,
  output logic [3:0]  oCursor_Hole,
  output logic [3:0]  oMole_Hole,
  output logic        oMole_Up,
  output logic [7:0]  oScore,
  output logic [3:0]  oMisses,
  output logic        oHit_Pulse,
  output logic        oMiss_Pulse,
  output logic        oGame_Over,
  output logic [2:0]  oState
);
  import mole_pkg::*;

  moleState_t  state_r;
  logic [7:0]  lfsr_r;
  logic [7:0]  frameCnt_r;
  logic [3:0]  debCnt_r;
  logic [3:0]  prevHole_r;
  logic [3:0]  mapHole_s;
  logic [3:0]  spawn_s;
  logic [3:0]  debNext_s;
  logic        lfsrFb_s;

  mole_grid_map #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H),
    .MARGIN (MARGIN)
  ) uGridMap (
    .iX    (iAvg_X),
    .iY    (iAvg_Y),
    .oHole (mapHole_s)
  );

  assign lfsrFb_s = ^(lfsr_r & LFSR_TAPS);
  assign spawn_s  = spawnHole(lfsr_r, prevHole_r);
  assign oState   = state_r;

  // Debounce count the current tick would produce while a mole is up.
  always_comb begin
    debNext_s = 4'd0;
    if (mapHole_s == oMole_Hole) debNext_s = debCnt_r + 4'd1;
    else                         debNext_s = 4'd0;
  end

  // Free-running LFSR and per-frame cursor capture.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lfsr_r       <= LFSR_SEED;
      oCursor_Hole <= NO_HOLE;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsrFb_s};
      if (iFrame_Tick) oCursor_Hole <= mapHole_s;
    end
  end

  // Round state machine with registered game outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r     <= ST_IDLE;
      frameCnt_r  <= 8'd0;
      debCnt_r    <= 4'd0;
      prevHole_r  <= NO_HOLE;
      oMole_Hole  <= NO_HOLE;
      oMole_Up    <= 1'b0;
      oScore      <= 8'd0;
      oMisses     <= 4'd0;
      oHit_Pulse  <= 1'b0;
      oMiss_Pulse <= 1'b0;
      oGame_Over  <= 1'b0;
    end else begin
      oHit_Pulse  <= 1'b0;
      oMiss_Pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iStart) begin
            state_r    <= ST_GAP;
            oScore     <= 8'd0;
            oMisses    <= 4'd0;
            frameCnt_r <= 8'd0;
          end
        end
        ST_GAP: begin
          if (iFrame_Tick) begin
            if (frameCnt_r == 8'(GAP_FRAMES - 1)) begin
              state_r    <= ST_UP;
              oMole_Hole <= spawn_s;
              prevHole_r <= spawn_s;
              oMole_Up   <= 1'b1;
              frameCnt_r <= 8'd0;
              debCnt_r   <= 4'd0;
            end else begin
              frameCnt_r <= frameCnt_r + 8'd1;
            end
          end
        end
        ST_UP: begin
          if (iFrame_Tick) begin
            debCnt_r <= debNext_s;
            // A hit on the final up frame beats the timeout.
            if (debNext_s == 4'(HIT_FRAMES)) begin
              state_r    <= ST_HIT;
              oHit_Pulse <= 1'b1;
              oScore     <= (oScore == 8'hFF) ? oScore : oScore + 8'd1;
              oMole_Up   <= 1'b0;
              oMole_Hole <= NO_HOLE;
            end else if (frameCnt_r == 8'(UP_FRAMES - 1)) begin
              state_r     <= ST_MISS;
              oMiss_Pulse <= 1'b1;
              oMisses     <= oMisses + 4'd1;
              oMole_Up    <= 1'b0;
              oMole_Hole  <= NO_HOLE;
            end else begin
              frameCnt_r <= frameCnt_r + 8'd1;
            end
          end
        end
        ST_HIT: begin
          state_r    <= ST_GAP;
          frameCnt_r <= 8'd0;
        end
        ST_MISS: begin
          state_r    <= (oMisses == 4'(MAX_MISS)) ? ST_OVER : ST_GAP;
          oGame_Over <= (oMisses == 4'(MAX_MISS));
          frameCnt_r <= 8'd0;
        end
        ST_OVER: begin
          if (iStart) begin
            state_r    <= ST_GAP;
            oScore     <= 8'd0;
            oMisses    <= 4'd0;
            frameCnt_r <= 8'd0;
            debCnt_r   <= 4'd0;
            oGame_Over <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
